// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data requester.
//
// - One transaction is outstanding at a time.
// - The data side has priority.
// - Each transaction walks IDLE -> BUSY_x -> RESP_x -> IDLE.
//
// Build option ARB_STARVE_GUARD_EN adds a starvation guard. Once STARVE_LIMIT
// back-to-back data grants have been made while fetch was waiting, fetch gets
// the next grant. Without the macro the arbiter is strict data-first, and no
// counter is built.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  // data side
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // pipeline stalls
  output logic        stall_if,
  output logic        stall_dm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        grant_if, grant_dm;
  logic        starved;

  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

`ifdef ARB_STARVE_GUARD_EN
  // The counter only has to reach STARVE_LIMIT, so size it for that value.
  // A limit of 0 still gets a 1-bit counter.
  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_q, starve_d;

  assign starved = (starve_q == CntW'(STARVE_LIMIT));

  // Count data grants made while fetch was waiting. Any grant that leaves
  // fetch not waiting clears the count.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_dm) begin
      if (!if_req)
        starve_d = '0;
      else if (!starved)
        starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  // With no guard the limit has no effect and fetch is never forced ahead.
  assign starved = (STARVE_LIMIT == 0) && 1'b0;
`endif

  // Next-state logic and grant decode.
  // Arbitration happens only in IDLE. Once a transaction is granted it runs
  // to completion even if the requester drops req.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req && !(if_req && starved)) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
        end
      end
      BUSY_IF: if (mem_ack) state_d = RESP_IF;
      BUSY_DM: if (mem_ack) state_d = RESP_DM;
      RESP_IF: state_d = IDLE;
      RESP_DM: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Memory request fields.
  // They are captured at grant time and then held, so the bus stays stable
  // through any number of wait states. Fetch is always a read.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_dm) begin
      mem_we_d    = dm_we;
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
    end else if (grant_if) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
    end
  end

  // Read data capture.
  // Data is latched on the BUSY->RESP edge. A data-side write must not
  // disturb the last data read value.
  always_comb begin
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (state_q == BUSY_IF && mem_ack)
      if_rdata_d = mem_rdata;
    if (state_q == BUSY_DM && mem_ack && !mem_we_q)
      dm_rdata_d = mem_rdata;
  end

  // Datapath registers. All of them clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Output decode.
  // Request and ack are decoded straight from state, so reset drops them
  // without waiting for a clock edge.
  assign mem_req   = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign if_ack    = (state_q == RESP_IF);
  assign dm_ack    = (state_q == RESP_DM);

  // mem_we is masked outside BUSY so that it reads 0 whenever the bus is idle.
  assign mem_we    = mem_we_q && (state_q == BUSY_DM);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign stall_if  = if_req & ~if_ack;
  assign stall_dm  = dm_req & ~dm_ack;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive data grants allowed while fetch waits (guard build only).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports if_req (in, 1), if_addr (in, 32): fetch read request and address.
REQ-005 SHALL have ports if_rdata (out, 32), if_ack (out, 1): fetch read data and completion pulse.
REQ-006 SHALL have ports dm_req, dm_we (in, 1 each), dm_addr, dm_wdata (in, 32 each): data-side request, write enable, address and write data.
REQ-007 SHALL have ports dm_rdata (out, 32), dm_ack (out, 1): data-side read data and completion pulse.
REQ-008 SHALL have ports mem_req, mem_we (out, 1 each), mem_addr, mem_wdata (out, 32 each): shared memory request bus.
REQ-009 SHALL have ports mem_rdata (in, 32), mem_ack (in, 1): shared memory response.
REQ-010 SHALL have ports stall_if, stall_dm (out, 1 each): pipeline stall requests per requester.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM.
REQ-012 IDLE: dm_req=1 -> BUSY_DM; else if_req=1 -> BUSY_IF; else stay; data wins ties (guard aside).
REQ-013 On leaving IDLE SHALL register granted address, and for data dm_we/dm_wdata, onto mem_addr/mem_we/mem_wdata (mem_we=0 for fetch).
REQ-014 mem_req SHALL be 1 exactly while in BUSY_IF or BUSY_DM; mem_addr/mem_we/mem_wdata stable throughout.
REQ-015 BUSY_x with mem_ack=1 -> RESP_x; no mem_ack -> stay (unbounded wait states).
REQ-016 On BUSY_x->RESP_x transition, reads SHALL register mem_rdata into x_rdata; data writes leave dm_rdata unchanged.
REQ-017 x_ack SHALL be 1 only in RESP_x, exactly one cycle; x_rdata SHALL hold value until next read completion for that side.
REQ-018 RESP_x SHALL go to IDLE unconditionally; minimum request-to-ack latency 2 cycles (mem_ack in first BUSY cycle), minimum issue interval 3 cycles.
REQ-019 stall_if SHALL equal if_req & ~if_ack; stall_dm SHALL equal dm_req & ~dm_ack (combinational).
REQ-020 Requester dropping req during BUSY SHALL NOT abort transaction; ack still pulses; ungranted request withdrawn in IDLE is ignored.
REQ-021 mem_ack outside BUSY states SHALL be ignored.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, abandoning any in-flight transaction.
REQ-023 Reset values: mem_req, mem_we, if_ack, dm_ack = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; starvation counter = 0.
REQ-024 First arbitration SHALL occur on first rising edge after rst deasserts.

Configuration
REQ-025 Macro ARB_STARVE_GUARD_EN SHALL control starvation guard.
REQ-026 Defined: counter increments on each data grant made while if_req=1, clears on any fetch grant or when data granted with if_req=0; when count equals STARVE_LIMIT and both request in IDLE, fetch SHALL be granted.
REQ-027 Undefined: strict data priority, no counter logic present; fetch may starve indefinitely.

Verification
REQ-028 Fetch read: if_req=1, if_addr=0x100, mem_ack in first BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req 1 cycle, if_ack one cycle later, if_rdata=0xDEADBEEF.
REQ-029 Data write with 2 wait states: dm_we=1, dm_addr=0x2000, dm_wdata=0x12345678 -> mem_req high 3 cycles with mem_we=1, dm_ack single pulse, dm_rdata unchanged.
REQ-030 Simultaneous if_req and dm_req in IDLE -> data granted first, fetch granted after RESP_DM->IDLE; stall_if=1 until if_ack.
REQ-031 Guard built, STARVE_LIMIT=4, dm_req and if_req held continuously -> 4 data grants, then 1 fetch grant, pattern repeats; unguarded build -> fetch never granted.
REQ-032 rst pulsed low mid BUSY_DM -> mem_req falls asynchronously, no dm_ack, all outputs 0; fresh if_req then completes normally.
